// File: rtl/ps2_pkg.sv
// Shared types, constants and scan-code translation for the PS/2 keyboard receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_e;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [7:0] ascii;
  } ps2_event_t;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;

  // Set-2 scan code to Apple-II ASCII (bit 7 set); 8'h00 for unmapped codes.
  function automatic logic [7:0] ps2_to_ascii(input logic [7:0] code, input logic shifted);
    logic [6:0] ch;
    ch = 7'h00;
    case (code)
      8'h1C: ch = 7'h41;  8'h32: ch = 7'h42;  8'h21: ch = 7'h43;  8'h23: ch = 7'h44;
      8'h24: ch = 7'h45;  8'h2B: ch = 7'h46;  8'h34: ch = 7'h47;  8'h33: ch = 7'h48;
      8'h43: ch = 7'h49;  8'h3B: ch = 7'h4A;  8'h42: ch = 7'h4B;  8'h4B: ch = 7'h4C;
      8'h3A: ch = 7'h4D;  8'h31: ch = 7'h4E;  8'h44: ch = 7'h4F;  8'h4D: ch = 7'h50;
      8'h15: ch = 7'h51;  8'h2D: ch = 7'h52;  8'h1B: ch = 7'h53;  8'h2C: ch = 7'h54;
      8'h3C: ch = 7'h55;  8'h2A: ch = 7'h56;  8'h1D: ch = 7'h57;  8'h22: ch = 7'h58;
      8'h35: ch = 7'h59;  8'h1A: ch = 7'h5A;
      8'h16: ch = shifted ? 7'h21 : 7'h31;
      8'h1E: ch = shifted ? 7'h40 : 7'h32;
      8'h26: ch = shifted ? 7'h23 : 7'h33;
      8'h25: ch = shifted ? 7'h24 : 7'h34;
      8'h2E: ch = shifted ? 7'h25 : 7'h35;
      8'h36: ch = shifted ? 7'h5E : 7'h36;
      8'h3D: ch = shifted ? 7'h26 : 7'h37;
      8'h3E: ch = shifted ? 7'h2A : 7'h38;
      8'h46: ch = shifted ? 7'h28 : 7'h39;
      8'h45: ch = shifted ? 7'h29 : 7'h30;
      8'h29: ch = 7'h20;  8'h5A: ch = 7'h0D;  8'h76: ch = 7'h1B;  8'h66: ch = 7'h08;
      default: ch = 7'h00;
    endcase
    return (ch == 7'h00) ? 8'h00 : {1'b1, ch};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 pin synchroniser, glitch filter, frame FSM and inter-edge timeout.
// Odd-parity checking is compiled in with PS2_KBD_PARITY_EN.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILT_LEN    = 16,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       CLOCK_50,
  input  logic       clr,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic       byte_stb,
  output logic [7:0] byte_data,
  output logic       err_stb
);

  // state     | meaning
  // ST_IDLE   | bus idle, waiting for a start bit (data 0 on fall)
  // ST_DATA   | shifting in 8 data bits, LSB first
  // ST_PARITY | sampling the parity bit
  // ST_STOP   | sampling the stop bit and judging the frame

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]          clk_sync, dat_sync;
  logic [FILT_LEN-1:0] clk_sr, dat_sr;
  logic                clk_filt, clk_filt_d, dat_filt, fall;
  frame_state_e        state, state_nx;
  logic [2:0]          bit_cnt, bit_cnt_nx;
  logic [7:0]          shreg, shreg_nx;
  logic [TW-1:0]       tmr;
  logic                timeout, good, byte_nx, err_nx;
`ifdef PS2_KBD_PARITY_EN
  logic                par, par_nx;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (clr) begin
      clk_sync   <= '1;
      dat_sync   <= '1;
      clk_sr     <= '1;
      dat_sr     <= '1;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
      dat_filt   <= 1'b1;
    end else begin
      clk_sync   <= {clk_sync[0], PS2_CLK};
      dat_sync   <= {dat_sync[0], PS2_DAT};
      clk_sr     <= {clk_sr[FILT_LEN-2:0], clk_sync[1]};
      dat_sr     <= {dat_sr[FILT_LEN-2:0], dat_sync[1]};
      if (&clk_sr)       clk_filt <= 1'b1;
      else if (~|clk_sr) clk_filt <= 1'b0;
      if (&dat_sr)       dat_filt <= 1'b1;
      else if (~|dat_sr) dat_filt <= 1'b0;
      clk_filt_d <= clk_filt;
    end
  end

  assign fall = clk_filt_d & ~clk_filt;

  // Reloaded on every fall; reaching zero outside IDLE means the keyboard stalled.
  always_ff @(posedge CLOCK_50) begin
    if (clr)              tmr <= '0;
    else if (fall)        tmr <= TW'(TIMEOUT_CYC);
    else if (tmr != '0)   tmr <= tmr - 1'b1;
  end

  assign timeout = (state != ST_IDLE) && (tmr == '0);

`ifdef PS2_KBD_PARITY_EN
  assign good = dat_filt & (^{par, shreg});
`else
  assign good = dat_filt;
`endif

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    byte_nx    = 1'b0;
    err_nx     = 1'b0;
`ifdef PS2_KBD_PARITY_EN
    par_nx     = par;
`endif
    if (timeout) begin
      state_nx = ST_IDLE;
      err_nx   = 1'b1;
    end else if (fall) begin
      case (state)
        ST_IDLE: if (!dat_filt) begin
          state_nx   = ST_DATA;
          bit_cnt_nx = 3'd0;
        end
        ST_DATA: begin
          shreg_nx   = {dat_filt, shreg[7:1]};
          bit_cnt_nx = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nx = ST_PARITY;
        end
        ST_PARITY: begin
`ifdef PS2_KBD_PARITY_EN
          par_nx   = dat_filt;
`endif
          state_nx = ST_STOP;
        end
        ST_STOP: begin
          state_nx = ST_IDLE;
          if (good) byte_nx = 1'b1;
          else      err_nx  = 1'b1;
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (clr) begin
      state    <= ST_IDLE;
      bit_cnt  <= 3'd0;
      shreg    <= 8'h00;
      byte_stb <= 1'b0;
      err_stb  <= 1'b0;
`ifdef PS2_KBD_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      state    <= state_nx;
      bit_cnt  <= bit_cnt_nx;
      shreg    <= shreg_nx;
      byte_stb <= byte_nx;
      err_stb  <= err_nx;
`ifdef PS2_KBD_PARITY_EN
      par      <= par_nx;
`endif
    end
  end

  // shreg is frozen in IDLE, so it is valid while byte_stb is high.
  assign byte_data = shreg;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver top: prefix decoding, shift tracking, ASCII lookup and event FIFO.
// Parity checking in the frame receiver is enabled by defining PS2_KBD_PARITY_EN.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FILT_LEN    = 16,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic       CLOCK_50,
  input  logic       clr,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_brk,
  output logic [7:0] ev_ascii,
  output logic       ovf,
  output logic [7:0] err_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic          byte_stb, err_stb;
  logic [7:0]    byte_data;
  logic          ext_p, brk_p, shift_l, shift_r;
  logic          push, pop, full, wr_en;
  logic [AW:0]   count;
  logic [AW-1:0] wr_ptr, rd_ptr;
  ps2_event_t    ev_new, head;
  ps2_event_t    mem [FIFO_DEPTH];

  ps2_frame_rx #(
    .FILT_LEN    (FILT_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_frame (
    .CLOCK_50  (CLOCK_50),
    .clr       (clr),
    .PS2_CLK   (PS2_CLK),
    .PS2_DAT   (PS2_DAT),
    .byte_stb  (byte_stb),
    .byte_data (byte_data),
    .err_stb   (err_stb)
  );

  assign push = byte_stb && (byte_data != PS2_EXT) && (byte_data != PS2_BRK);

  always_comb begin
    ev_new.code  = byte_data;
    ev_new.ext   = ext_p;
    ev_new.brk   = brk_p;
    ev_new.ascii = (ext_p | brk_p) ? 8'h00 : ps2_to_ascii(byte_data, shift_l | shift_r);
  end

  always_ff @(posedge CLOCK_50) begin
    if (clr) begin
      ext_p   <= 1'b0;
      brk_p   <= 1'b0;
      shift_l <= 1'b0;
      shift_r <= 1'b0;
    end else if (byte_stb) begin
      if (byte_data == PS2_EXT)      ext_p <= 1'b1;
      else if (byte_data == PS2_BRK) brk_p <= 1'b1;
      else begin
        ext_p <= 1'b0;
        brk_p <= 1'b0;
        if (byte_data == PS2_LSHIFT) shift_l <= ~brk_p;
        if (byte_data == PS2_RSHIFT) shift_r <= ~brk_p;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (clr)                                err_cnt <= 8'h00;
    else if (err_stb && err_cnt != 8'hFF)   err_cnt <= err_cnt + 8'd1;
  end

  assign ev_valid = (count != '0);
  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign pop      = ev_valid & ev_ready;
  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign wr_en    = push & (~full | pop);

  always_ff @(posedge CLOCK_50) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)      count <= count + 1'b1;
      else if (!wr_en && pop) count <= count - 1'b1;
      if (push && full && !pop) ovf <= 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (wr_en) mem[wr_ptr] <= ev_new;
  end

  assign head     = ev_valid ? mem[rd_ptr] : '0;
  assign ev_code  = head.code;
  assign ev_ext   = head.ext;
  assign ev_brk   = head.brk;
  assign ev_ascii = head.ascii;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: frame table plus timeout, overflow and reset sequences.
module tb_ps2_kbd_rx;

  localparam int FILT_LEN    = 4;
  localparam int TIMEOUT_CYC = 400;
  localparam int FIFO_DEPTH  = 4;
  localparam int HALF        = 16;
`ifdef PS2_KBD_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       clr = 1'b1;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DAT = 1'b1;
  logic       ev_ready = 1'b0;
  logic       ev_valid, ev_ext, ev_brk, ovf;
  logic [7:0] ev_code, ev_ascii, err_cnt;

  always #5 CLOCK_50 = ~CLOCK_50;

  ps2_kbd_rx #(
    .FILT_LEN    (FILT_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .clr      (clr),
    .PS2_CLK  (PS2_CLK),
    .PS2_DAT  (PS2_DAT),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_code  (ev_code),
    .ev_ext   (ev_ext),
    .ev_brk   (ev_brk),
    .ev_ascii (ev_ascii),
    .ovf      (ovf),
    .err_cnt  (err_cnt)
  );

  typedef struct {
    logic [7:0] data;
    logic       bad_par;
    logic       bad_stop;
    logic       exp_ev;
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [7:0] ascii;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  // Bits go out start, d0..d7, parity, stop; pop_at_stop pulses ev_ready in the push cycle.
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                            input int nbits, input logic pop_at_stop);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge CLOCK_50);
      PS2_DAT = bits[i];
      wait_neg(HALF);
      PS2_CLK = 1'b0;
      if (pop_at_stop && i == 10) begin
        repeat (FILT_LEN + 4) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        ev_ready = 1'b1;
        @(negedge CLOCK_50);
        ev_ready = 1'b0;
        wait_neg(HALF - FILT_LEN - 6);
      end else begin
        wait_neg(HALF);
      end
      PS2_CLK = 1'b1;
    end
    wait_neg(HALF);
    PS2_DAT = 1'b1;
    wait_neg(2 * HALF);
  endtask

  task automatic pop_ev();
    @(negedge CLOCK_50);
    ev_ready = 1'b1;
    @(negedge CLOCK_50);
    ev_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    clr = 1'b1;
    wait_neg(4);
    clr = 1'b0;
    wait_neg(1);
  endtask

  task automatic chk_head(input string name, input logic [7:0] code, input logic ext,
                          input logic brk, input logic [7:0] ascii);
    chk({name, " valid"}, 32'(ev_valid), 32'(1'b1));
    chk({name, " event"}, 32'({ev_code, ev_ext, ev_brk, ev_ascii}), 32'({code, ext, brk, ascii}));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] ov_codes [5];
    logic [7:0] sp_codes [5];
    vec_t v;

    vq.push_back('{8'h1C, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 8'hC1});
    vq.push_back('{8'hF0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00});
    vq.push_back('{8'h1C, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b1, 8'h00});
    vq.push_back('{8'h12, 1'b0, 1'b0, 1'b1, 8'h12, 1'b0, 1'b0, 8'h00});
    vq.push_back('{8'h16, 1'b0, 1'b0, 1'b1, 8'h16, 1'b0, 1'b0, 8'hA1});
    vq.push_back('{8'hF0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00});
    vq.push_back('{8'h12, 1'b0, 1'b0, 1'b1, 8'h12, 1'b0, 1'b1, 8'h00});
    vq.push_back('{8'h16, 1'b0, 1'b0, 1'b1, 8'h16, 1'b0, 1'b0, 8'hB1});
    vq.push_back('{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00});
    vq.push_back('{8'h6B, 1'b0, 1'b0, 1'b1, 8'h6B, 1'b1, 1'b0, 8'h00});
    vq.push_back('{8'h59, 1'b0, 1'b0, 1'b1, 8'h59, 1'b0, 1'b0, 8'h00});
    vq.push_back('{8'h1E, 1'b0, 1'b0, 1'b1, 8'h1E, 1'b0, 1'b0, 8'hC0});
    vq.push_back('{8'hF0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00});
    vq.push_back('{8'h59, 1'b0, 1'b0, 1'b1, 8'h59, 1'b0, 1'b1, 8'h00});
    vq.push_back('{8'h1E, 1'b0, 1'b0, 1'b1, 8'h1E, 1'b0, 1'b0, 8'hB2});
    vq.push_back('{8'h5A, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 8'h8D});
    vq.push_back('{8'h29, 1'b0, 1'b0, 1'b1, 8'h29, 1'b0, 1'b0, 8'hA0});
    vq.push_back('{8'h32, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00});
    vq.push_back('{8'h76, 1'b0, 1'b0, 1'b1, 8'h76, 1'b0, 1'b0, 8'h9B});
    vq.push_back('{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00});
    vq.push_back('{8'hF0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00});
    vq.push_back('{8'h1C, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b1, 1'b1, 8'h00});
`ifdef PS2_KBD_PARITY_EN
    vq.push_back('{8'h1C, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00});
`else
    vq.push_back('{8'h1C, 1'b1, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 8'hC1});
`endif
    vq.push_back('{8'h15, 1'b0, 1'b0, 1'b1, 8'h15, 1'b0, 1'b0, 8'hD1});

    ov_codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24};
    sp_codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};

    do_reset();
    chk("reset ev_valid", 32'(ev_valid), 32'(1'b0));
    chk("reset head", 32'({ev_code, ev_ext, ev_brk, ev_ascii}), 32'(0));
    chk("reset ovf", 32'(ovf), 32'(1'b0));
    chk("reset err_cnt", 32'(err_cnt), 32'(0));

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      send_frame(v.data, v.bad_par, v.bad_stop, 11, 1'b0);
      if (v.bad_stop || (PAR_EN && v.bad_par)) exp_err++;
      chk($sformatf("row%0d valid", i), 32'(ev_valid), 32'(v.exp_ev));
      if (v.exp_ev) begin
        chk($sformatf("row%0d event", i), 32'({ev_code, ev_ext, ev_brk, ev_ascii}),
            32'({v.code, v.ext, v.brk, v.ascii}));
        pop_ev();
        chk($sformatf("row%0d drained", i), 32'(ev_valid), 32'(1'b0));
      end
      chk($sformatf("row%0d err_cnt", i), 32'(err_cnt), 32'(exp_err));
    end

    // Partial frame then silence: the timeout must discard it and count one error.
    send_frame(8'hFF, 1'b0, 1'b0, 5, 1'b0);
    wait_neg(TIMEOUT_CYC + 50);
    exp_err++;
    chk("timeout err_cnt", 32'(err_cnt), 32'(exp_err));
    chk("timeout no event", 32'(ev_valid), 32'(1'b0));
    send_frame(8'h1C, 1'b0, 1'b0, 11, 1'b0);
    chk_head("after timeout", 8'h1C, 1'b0, 1'b0, 8'hC1);
    pop_ev();
    chk("after timeout err_cnt", 32'(err_cnt), 32'(exp_err));

    // Overflow: one more make code than the FIFO holds.
    for (int i = 0; i < FIFO_DEPTH; i++) send_frame(ov_codes[i], 1'b0, 1'b0, 11, 1'b0);
    chk("full no ovf", 32'(ovf), 32'(1'b0));
    send_frame(ov_codes[FIFO_DEPTH], 1'b0, 1'b0, 11, 1'b0);
    chk("ovf set", 32'(ovf), 32'(1'b1));
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      chk($sformatf("ovf drain%0d valid", i), 32'(ev_valid), 32'(1'b1));
      chk($sformatf("ovf drain%0d code", i), 32'(ev_code), 32'(ov_codes[i]));
      pop_ev();
    end
    chk("ovf drained", 32'(ev_valid), 32'(1'b0));
    chk("ovf sticky", 32'(ovf), 32'(1'b1));

    do_reset();
    chk("clr ovf", 32'(ovf), 32'(1'b0));
    chk("clr err_cnt", 32'(err_cnt), 32'(0));
    chk("clr ev_valid", 32'(ev_valid), 32'(1'b0));

    // Push and pop in the same cycle while full.
    for (int i = 0; i < FIFO_DEPTH; i++) send_frame(sp_codes[i], 1'b0, 1'b0, 11, 1'b0);
    send_frame(sp_codes[FIFO_DEPTH], 1'b0, 1'b0, 11, 1'b1);
    chk("simul no ovf", 32'(ovf), 32'(1'b0));
    for (int i = 1; i <= FIFO_DEPTH; i++) begin
      chk($sformatf("simul drain%0d valid", i), 32'(ev_valid), 32'(1'b1));
      chk($sformatf("simul drain%0d code", i), 32'(ev_code), 32'(sp_codes[i]));
      pop_ev();
    end
    chk("simul drained", 32'(ev_valid), 32'(1'b0));

    // clr in the middle of a frame discards it without counting an error.
    send_frame(8'h55, 1'b0, 1'b0, 6, 1'b0);
    do_reset();
    send_frame(8'h1C, 1'b0, 1'b0, 11, 1'b0);
    chk_head("after midframe clr", 8'h1C, 1'b0, 1'b0, 8'hC1);
    pop_ev();
    chk("midframe clr err_cnt", 32'(err_cnt), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
